// File: rtl/inst_mem_server.sv
// Instruction-memory responder: valid/ready fetch port, synchronous RAM, 2-entry response FIFO.
// Define IMEM_BOUNDS_CHECK_EN to flag fetches and ignore program writes above the decoded range.
module inst_mem_server #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] req_addr,
    input  logic        flush,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_inst,
    output logic [31:0] rsp_pc,
    output logic        rsp_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;

    logic        rst_active;
    logic        inflight;
    logic [31:0] s1_pc;
    logic        s1_err;

    logic [31:0] fifo_inst [2];
    logic [31:0] fifo_pc [2];
    logic [1:0]  fifo_err;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        accept;
    logic        pop;
    logic        push;
    logic        req_err;
    logic        out_of_range;
    logic        prog_ok;
    logic [2:0]  occupancy;
    logic        unused_bits;

`ifdef IMEM_BOUNDS_CHECK_EN
    assign out_of_range = |req_addr[31:ADDR_W];
    assign prog_ok      = ~|prog_addr[31:ADDR_W];
    assign unused_bits  = ^prog_addr[1:0];
`else
    // Upper address bits alias, so they are deliberately left undecoded.
    assign out_of_range = 1'b0;
    assign prog_ok      = 1'b1;
    assign unused_bits  = ^{req_addr[31:ADDR_W], prog_addr[31:ADDR_W], prog_addr[1:0]};
`endif

    assign req_err   = (|req_addr[1:0]) || out_of_range;
    assign rsp_vld   = (count != 2'd0);
    assign pop       = rsp_vld && rsp_rdy;
    assign push      = inflight && !flush;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign req_rdy   = !prog_we && !rst_active && (occupancy < 3'd2);
    assign accept    = req_vld && req_rdy;

    assign rsp_inst  = fifo_inst[rd_ptr];
    assign rsp_pc    = fifo_pc[rd_ptr];
    assign rsp_err   = fifo_err[rd_ptr];

    // Holds req_rdy low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_active <= 1'b1;
        else        rst_active <= 1'b0;
    end

    // RAM contents survive reset; program writes never collide with a read since they block accept.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) mem[prog_addr[ADDR_W-1:2]] <= prog_wdata;
        if (accept)             ram_q <= mem[req_addr[ADDR_W-1:2]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            s1_pc    <= 32'd0;
            s1_err   <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                s1_pc  <= req_addr;
                s1_err <= req_err;
            end
        end
    end

    // A flush drops both the buffered entries and the read completing this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_inst[i] <= NOP_INST;
                fifo_pc[i]   <= 32'd0;
            end
            fifo_err <= 2'b00;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= s1_err ? NOP_INST : ram_q;
                fifo_pc[wr_ptr]   <= s1_pc;
                fifo_err[wr_ptr]  <= s1_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
